// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder: FSM encoding, prefix scancodes
// and the set-2 scancode to ASCII translation.
package ps2_key_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_POP    = 2'd1,
      ST_DECODE = 2'd2
   } state_t;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;

   function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
      logic [7:0] a;
      a = 8'h00;
      case (sc)
         8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
         8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
         8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
         8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
         8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
         8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
         8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
         8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
         8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;  8'h46: a = 8'h39;
         8'h29: a = 8'h20;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_hex7seg.sv
// Hex nibble to active-low 7-segment pattern: bit7=a .. bit1=g, bit0=dp (always off).
module hex7seg (
   input  logic [3:0] i_hex,
   output logic [7:0] o_seg
);

   always_comb begin
      case (i_hex)
         4'h0: o_seg = 8'h03;
         4'h1: o_seg = 8'h9F;
         4'h2: o_seg = 8'h25;
         4'h3: o_seg = 8'h0D;
         4'h4: o_seg = 8'h99;
         4'h5: o_seg = 8'h49;
         4'h6: o_seg = 8'h41;
         4'h7: o_seg = 8'h1F;
         4'h8: o_seg = 8'h01;
         4'h9: o_seg = 8'h09;
         4'hA: o_seg = 8'h11;
         4'hB: o_seg = 8'hC1;
         4'hC: o_seg = 8'h63;
         4'hD: o_seg = 8'h85;
         4'hE: o_seg = 8'h61;
         default: o_seg = 8'h71;
      endcase
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: pops one byte per 3 cycles from the keyboard FIFO,
// tracks E0/F0 prefixes, reports presses and drives six hex digits.
module ps2_key_decoder (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] ps2_data,
   input  logic       ps2_ready,
   input  logic       ps2_overflow,
   output logic       nextdata_n,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic [7:0] key_ascii,
   output logic       key_pressed,
   output logic [7:0] key_count,
   output logic       err,
   output logic [7:0] seg0,
   output logic [7:0] seg1,
   output logic [7:0] seg2,
   output logic [7:0] seg3,
   output logic [7:0] seg4,
   output logic [7:0] seg5
);

   import ps2_key_decoder_pkg::*;

   state_t     r_state;
   state_t     w_next_state;
   logic [7:0] r_byte;
   logic       r_ext_f;
   logic       r_brk_f;
   logic       r_key_valid;
   logic [7:0] r_key_code;
   logic       r_key_ext;
   logic [7:0] r_key_ascii;
   logic       r_key_pressed;
   logic [7:0] r_key_count;
   logic       r_err;
   logic       w_match;
   logic [7:0] w_seg [6];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   // NOTE: defaults come first so no path through the case leaves an output unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      nextdata_n   = 1'b1;
      case (r_state)
         ST_IDLE:   if (ps2_ready) w_next_state = ST_POP;
         ST_POP: begin
            nextdata_n   = 1'b0;
            w_next_state = ST_DECODE;
         end
         ST_DECODE: w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   assign w_match = ({r_ext_f, r_byte} == {r_key_ext, r_key_code});

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_byte        <= 8'h00;
         r_ext_f       <= 1'b0;
         r_brk_f       <= 1'b0;
         r_key_valid   <= 1'b0;
         r_key_code    <= 8'h00;
         r_key_ext     <= 1'b0;
         r_key_ascii   <= 8'h00;
         r_key_pressed <= 1'b0;
         r_key_count   <= 8'h00;
         r_err         <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (ps2_overflow) r_err <= 1'b1;
         if (r_state == ST_IDLE && ps2_ready) r_byte <= ps2_data;
         if (r_state == ST_DECODE) begin
            if (r_byte == SC_EXT) begin
               r_ext_f <= 1'b1;
            end else if (r_byte == SC_BRK) begin
               r_brk_f <= 1'b1;
            end else if (r_brk_f) begin
               // Releasing a key other than the held one leaves the held key alone.
               if (w_match) r_key_pressed <= 1'b0;
               r_brk_f <= 1'b0;
               r_ext_f <= 1'b0;
            end else if (r_key_pressed && w_match) begin
               r_ext_f <= 1'b0;
            end else begin
               r_key_code    <= r_byte;
               r_key_ext     <= r_ext_f;
               r_key_ascii   <= r_ext_f ? 8'h00 : scan_to_ascii(r_byte);
               r_key_pressed <= 1'b1;
               r_key_count   <= r_key_count + 8'd1;
               r_key_valid   <= 1'b1;
               r_ext_f       <= 1'b0;
            end
         end
      end
   end

   hex7seg u_seg0 (.i_hex(r_key_code[3:0]),  .o_seg(w_seg[0]));
   hex7seg u_seg1 (.i_hex(r_key_code[7:4]),  .o_seg(w_seg[1]));
   hex7seg u_seg2 (.i_hex(r_key_ascii[3:0]), .o_seg(w_seg[2]));
   hex7seg u_seg3 (.i_hex(r_key_ascii[7:4]), .o_seg(w_seg[3]));
   hex7seg u_seg4 (.i_hex(r_key_count[3:0]), .o_seg(w_seg[4]));
   hex7seg u_seg5 (.i_hex(r_key_count[7:4]), .o_seg(w_seg[5]));

   assign seg0 = r_key_pressed ? w_seg[0] : 8'hFF;
   assign seg1 = r_key_pressed ? w_seg[1] : 8'hFF;
   assign seg2 = r_key_pressed ? w_seg[2] : 8'hFF;
   assign seg3 = r_key_pressed ? w_seg[3] : 8'hFF;
   assign seg4 = w_seg[4];
   assign seg5 = w_seg[5];

   assign key_valid   = r_key_valid;
   assign key_code    = r_key_code;
   assign key_ext     = r_key_ext;
   assign key_ascii   = r_key_ascii;
   assign key_pressed = r_key_pressed;
   assign key_count   = r_key_count;
   assign err         = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with a behavioural keyboard FIFO.
module tb_ps2_key_decoder;

   logic       clk;
   logic       resetn;
   logic [7:0] ps2_data;
   logic       ps2_ready;
   logic       ps2_overflow;
   logic       nextdata_n;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic [7:0] key_ascii;
   logic       key_pressed;
   logic [7:0] key_count;
   logic       err;
   logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;

   int         n_checks;
   int         n_errors;
   int         cyc;
   int         pop_cnt;
   int         kv_cnt;
   int         pop_cyc[$];
   logic [7:0] fifo[$];

   ps2_key_decoder dut (
      .clk(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
      .ps2_overflow(ps2_overflow), .nextdata_n(nextdata_n), .key_valid(key_valid),
      .key_code(key_code), .key_ext(key_ext), .key_ascii(key_ascii),
      .key_pressed(key_pressed), .key_count(key_count), .err(err),
      .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model and pulse monitor, evaluated mid-cycle on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (nextdata_n === 1'b0) begin
         pop_cnt = pop_cnt + 1;
         pop_cyc.push_back(cyc);
         if (fifo.size() != 0) void'(fifo.pop_front());
      end
      if (key_valid === 1'b1) kv_cnt = kv_cnt + 1;
      ps2_ready = (fifo.size() != 0);
      ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      fifo.delete();
      repeat (2) @(negedge clk);
      resetn  = 1'b1;
      kv_cnt  = 0;
      pop_cnt = 0;
      pop_cyc.delete();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (fifo.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(fifo.size() == 0), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      n_checks = 0; n_errors = 0; cyc = 0; pop_cnt = 0; kv_cnt = 0;
      resetn = 1'b0; ps2_overflow = 1'b0; ps2_ready = 1'b0; ps2_data = 8'h00;

      // Reset held with a byte waiting: nothing may be popped.
      fifo.push_back(8'h1C);
      repeat (5) @(negedge clk);
      check("rst_nextdata_n", nextdata_n, 1);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_code", key_code, 8'h00);
      check("rst_key_ext", key_ext, 0);
      check("rst_key_ascii", key_ascii, 8'h00);
      check("rst_key_pressed", key_pressed, 0);
      check("rst_key_count", key_count, 8'h00);
      check("rst_err", err, 0);
      check("rst_seg3_0", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFFF);
      check("rst_seg5_4", {seg5, seg4}, 32'h0303);
      check("rst_no_pop", pop_cnt, 0);

      // 1C make, then F0 1C release.
      resetn = 1'b1;
      drain("drain_make_a");
      check("a_code", key_code, 8'h1C);
      check("a_ascii", key_ascii, 8'h41);
      check("a_count", key_count, 8'h01);
      check("a_pressed", key_pressed, 1);
      check("a_seg3_0", {seg3, seg2, seg1, seg0}, 32'h999F_9F63);
      check("a_seg5_4", {seg5, seg4}, 32'h039F);
      fifo.push_back(8'hF0); fifo.push_back(8'h1C);
      drain("drain_rel_a");
      check("a_rel_pressed", key_pressed, 0);
      check("a_rel_count", key_count, 8'h01);
      check("a_rel_kv_pulses", kv_cnt, 1);
      check("a_rel_blank", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFFF);

      // Typematic repeat.
      do_reset();
      fifo.push_back(8'h1C); fifo.push_back(8'h1C); fifo.push_back(8'h1C);
      drain("drain_repeat");
      check("rep_count", key_count, 8'h01);
      check("rep_kv_pulses", kv_cnt, 1);
      check("rep_pressed", key_pressed, 1);

      // Extended key make and release.
      do_reset();
      fifo.push_back(8'hE0); fifo.push_back(8'h75);
      drain("drain_ext_make");
      check("ext_key_ext", key_ext, 1);
      check("ext_code", key_code, 8'h75);
      check("ext_ascii", key_ascii, 8'h00);
      check("ext_pressed", key_pressed, 1);
      fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
      drain("drain_ext_rel");
      check("ext_rel_pressed", key_pressed, 0);
      check("ext_rel_count", key_count, 8'h01);

      // Release of a key that is not held.
      do_reset();
      fifo.push_back(8'h1C); fifo.push_back(8'hF0); fifo.push_back(8'h32);
      drain("drain_foreign_rel");
      check("foreign_pressed", key_pressed, 1);
      check("foreign_code", key_code, 8'h1C);

      // 256 alternating makes wrap the counter.
      do_reset();
      for (int i = 0; i < 256; i++) fifo.push_back((i % 2 == 0) ? 8'h1C : 8'h32);
      drain("drain_wrap");
      check("wrap_count", key_count, 8'h00);
      check("wrap_seg5_4", {seg5, seg4}, 32'h0303);
      check("wrap_kv_pulses", kv_cnt, 256);
      check("wrap_code", key_code, 8'h32);

      // Reset discards pending E0 F0.
      do_reset();
      fifo.push_back(8'hE0); fifo.push_back(8'hF0);
      drain("drain_prefix");
      do_reset();
      fifo.push_back(8'h1C);
      drain("drain_after_rst");
      check("prefix_count", key_count, 8'h01);
      check("prefix_ext", key_ext, 0);
      check("prefix_pressed", key_pressed, 1);

      // Five-byte backlog: pop pulses spaced 3 cycles apart.
      do_reset();
      fifo.push_back(8'h16); fifo.push_back(8'h1E); fifo.push_back(8'h26);
      fifo.push_back(8'h25); fifo.push_back(8'h2E);
      drain("drain_backlog");
      repeat (6) @(negedge clk);
      check("backlog_pops", pop_cnt, 5);
      for (int i = 1; i < pop_cyc.size(); i++)
         check($sformatf("backlog_gap%0d", i), pop_cyc[i] - pop_cyc[i-1], 3);
      check("backlog_count", key_count, 8'h05);
      check("backlog_ascii", key_ascii, 8'h35);
      check("backlog_seg3_0", {seg3, seg2, seg1, seg0}, 32'h0D49_2561);
      check("backlog_seg4", seg4, 8'h49);

      // Space and digit zero mapping.
      do_reset();
      fifo.push_back(8'h29);
      drain("drain_space");
      check("space_ascii", key_ascii, 8'h20);
      fifo.push_back(8'h45);
      drain("drain_zero");
      check("zero_ascii", key_ascii, 8'h30);

      // Sticky overflow error.
      check("err_before", err, 0);
      @(negedge clk); ps2_overflow = 1'b1;
      @(negedge clk); ps2_overflow = 1'b0;
      repeat (3) @(negedge clk);
      check("err_sticky", err, 1);
      do_reset();
      @(negedge clk);
      check("err_cleared", err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
